// File: rtl/quad_gray_decoder.sv
// Quadrature Gray decoder: 2-FF sync, per-channel debounce, phase decode, wrapping position counter.
// Define QUAD_X4_EN to count every legal phase transition; otherwise only the 10<->00 edge is counted.
module quad_gray_decoder #(
    parameter int COUNT_W  = 8,
    parameter int DEB_CYC  = 100000,
    parameter int SETTLE_W = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               clr,
    output logic [COUNT_W-1:0] count,
    output logic               dir,
    output logic               step,
    output logic               err,
    output logic               ready
);

    typedef enum logic {
        INIT,
        TRACK
    } state_t;

    localparam logic [SETTLE_W-1:0] DEB_LAST    = SETTLE_W'(DEB_CYC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(DEB_CYC + 2);

    state_t              state;
    state_t              state_next;
    logic [1:0]          s1;
    logic [1:0]          s2;
    logic [1:0]          filt;
    logic [SETTLE_W-1:0] deb_cnt [2];
    logic [SETTLE_W-1:0] settle;
    logic [SETTLE_W-1:0] settle_next;
    logic [1:0]          ph;
    logic [1:0]          prev;
    logic [1:0]          prev_next;
    logic [COUNT_W-1:0]  count_next;
    logic                dir_next;
    logic                step_next;
    logic                err_next;
    logic                ready_next;
    logic                fwd;
    logic                bwd;
    logic                jump;
    logic                cnt_up;
    logic                cnt_dn;

    function automatic logic [1:0] gray_next(input logic [1:0] p);
        case (p)
            2'b00:   gray_next = 2'b01;
            2'b01:   gray_next = 2'b11;
            2'b11:   gray_next = 2'b10;
            default: gray_next = 2'b00;
        endcase
    endfunction

    // A bounce back to the filtered value restarts that channel's count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1         <= '0;
            s2         <= '0;
            filt       <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            s1 <= {enc_b, enc_a};
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    filt[i]    <= s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + SETTLE_W'(1);
                end
            end
        end
    end

    assign ph   = filt;
    assign fwd  = (ph == gray_next(prev));
    assign bwd  = (prev == gray_next(ph));
    assign jump = (ph == ~prev);

`ifdef QUAD_X4_EN
    assign cnt_up = fwd;
    assign cnt_dn = bwd;
`else
    assign cnt_up = fwd && (prev == 2'b10);
    assign cnt_dn = bwd && (prev == 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= INIT;
            settle <= '0;
            prev   <= '0;
            count  <= '0;
            dir    <= 1'b0;
            step   <= 1'b0;
            err    <= 1'b0;
            ready  <= 1'b0;
        end else begin
            state  <= state_next;
            settle <= settle_next;
            prev   <= prev_next;
            count  <= count_next;
            dir    <= dir_next;
            step   <= step_next;
            err    <= err_next;
            ready  <= ready_next;
        end
    end

    // INIT waits out the sync + debounce pipeline so the power-on phase never reads as a step.
    always_comb begin
        state_next  = state;
        settle_next = settle;
        case (state)
            INIT: begin
                if (settle == SETTLE_DONE) begin
                    state_next = TRACK;
                end else begin
                    settle_next = settle + SETTLE_W'(1);
                end
            end
            default: state_next = TRACK;
        endcase
    end

    always_comb begin
        prev_next  = prev;
        count_next = count;
        dir_next   = dir;
        step_next  = 1'b0;
        err_next   = err;
        ready_next = ready;
        case (state)
            INIT: begin
                if (settle == SETTLE_DONE) begin
                    prev_next  = ph;
                    ready_next = 1'b1;
                end
            end
            default: begin
                prev_next = ph;
                if (fwd) begin
                    dir_next = 1'b1;
                end else if (bwd) begin
                    dir_next = 1'b0;
                end
                if (cnt_up) begin
                    count_next = count + COUNT_W'(1);
                    step_next  = 1'b1;
                end else if (cnt_dn) begin
                    count_next = count - COUNT_W'(1);
                    step_next  = 1'b1;
                end
                if (jump) begin
                    err_next = 1'b1;
                end
            end
        endcase
        // Clear wins over a coincident step, but the step still pulses.
        if (clr) begin
            count_next = '0;
            err_next   = 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_gray_decoder.sv
// Directed self-checking bench for quad_gray_decoder with DEB_CYC=4, COUNT_W=8.
// Expected counts follow QUAD_X4_EN when it is defined for the build.
module tb_quad_gray_decoder;

    localparam int COUNT_W  = 8;
    localparam int DEB_CYC  = 4;
    localparam int SETTLE_W = 20;

`ifdef QUAD_X4_EN
    localparam int X4 = 1;
`else
    localparam int X4 = 0;
`endif

    localparam int FWD_COUNT  = X4 ? 4 : 1;
    localparam int BWD_COUNT  = X4 ? 252 : 255;
    localparam int PRE_CLR    = X4 ? 3 : 0;
    localparam int AFTER_JUMP = X4 ? 2 : 1;
    localparam int MID_COUNT  = X4 ? 1 : 0;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               enc_a = 1'b0;
    logic               enc_b = 1'b0;
    logic               clr   = 1'b0;
    logic [COUNT_W-1:0] count;
    logic               dir;
    logic               step;
    logic               err;
    logic               ready;

    int   checks      = 0;
    int   errors      = 0;
    int   step_pulses = 0;
    int   wide_pulses = 0;
    logic last_step   = 1'b0;

    quad_gray_decoder #(
        .COUNT_W (COUNT_W),
        .DEB_CYC (DEB_CYC),
        .SETTLE_W(SETTLE_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .clr  (clr),
        .count(count),
        .dir  (dir),
        .step (step),
        .err  (err),
        .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [1:0] ph, input logic c);
        rst_n = r;
        enc_b = ph[1];
        enc_a = ph[0];
        clr   = c;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance n falling edges, tallying step pulses and any pulse longer than one cycle.
    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                step_pulses++;
                if (last_step) wide_pulses++;
            end
            last_step = (step === 1'b1);
        end
    endtask

    initial begin
        // Phase 11 held through reset release is absorbed by INIT.
        applyStimulus(1'b0, 2'b11, 1'b0);
        hold(3);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_dir", 32'(dir), 0);
        checkOutput("rst_step", 32'(step), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_ready", 32'(ready), 0);
        applyStimulus(1'b1, 2'b11, 1'b0);
        step_pulses = 0;
        hold(6);
        checkOutput("init11_ready_early", 32'(ready), 0);
        hold(1);
        checkOutput("init11_ready", 32'(ready), 1);
        hold(10);
        checkOutput("init11_err", 32'(err), 0);
        checkOutput("init11_count", 32'(count), 0);
        checkOutput("init11_pulses", 32'(step_pulses), 0);

        // Reset again with 00; ready on the 7th edge after release.
        applyStimulus(1'b0, 2'b00, 1'b0);
        hold(2);
        checkOutput("rst2_ready", 32'(ready), 0);
        applyStimulus(1'b1, 2'b00, 1'b0);
        step_pulses = 0;
        hold(6);
        checkOutput("init00_ready_early", 32'(ready), 0);
        hold(1);
        checkOutput("init00_ready", 32'(ready), 1);
        hold(10);
        checkOutput("init00_count", 32'(count), 0);
        checkOutput("init00_err", 32'(err), 0);
        checkOutput("init00_pulses", 32'(step_pulses), 0);

        // Forward detent cycle, checking latency on the final 10->00 edge.
        step_pulses = 0;
        wide_pulses = 0;
        applyStimulus(1'b1, 2'b01, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b11, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b10, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b00, 1'b0);
        hold(6);
        checkOutput("lat_before", 32'(step), 0);
        hold(1);
        checkOutput("lat_edge", 32'(step), 1);
        hold(3);
        checkOutput("fwd_count", 32'(count), FWD_COUNT);
        checkOutput("fwd_pulses", 32'(step_pulses), FWD_COUNT);
        checkOutput("fwd_dir", 32'(dir), 1);
        checkOutput("fwd_width", 32'(wide_pulses), 0);

        // Three-cycle glitch on A must not get through the debounce.
        step_pulses = 0;
        applyStimulus(1'b1, 2'b01, 1'b0); hold(3);
        applyStimulus(1'b1, 2'b00, 1'b0); hold(10);
        checkOutput("glitch_count", 32'(count), FWD_COUNT);
        checkOutput("glitch_pulses", 32'(step_pulses), 0);

        // Clear, then backward cycle wraps below zero.
        applyStimulus(1'b1, 2'b00, 1'b1); hold(1);
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkOutput("clr_count", 32'(count), 0);
        step_pulses = 0;
        applyStimulus(1'b1, 2'b10, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b11, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b01, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b00, 1'b0); hold(10);
        checkOutput("bwd_count", 32'(count), BWD_COUNT);
        checkOutput("bwd_dir", 32'(dir), 0);
        checkOutput("bwd_pulses", 32'(step_pulses), FWD_COUNT);

        // Forward cycle wraps all-ones back up to zero.
        applyStimulus(1'b1, 2'b01, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b11, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b10, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b00, 1'b0); hold(10);
        checkOutput("wrap_count", 32'(count), 0);

        // Clear coincident with the counted 10->00 step.
        applyStimulus(1'b1, 2'b01, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b11, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b10, 1'b0); hold(10);
        checkOutput("preclr_count", 32'(count), PRE_CLR);
        applyStimulus(1'b1, 2'b00, 1'b0); hold(6);
        applyStimulus(1'b1, 2'b00, 1'b1); hold(1);
        checkOutput("clrstep_count", 32'(count), 0);
        checkOutput("clrstep_step", 32'(step), 1);
        checkOutput("clrstep_dir", 32'(dir), 1);
        applyStimulus(1'b1, 2'b00, 1'b0);
        step_pulses = 0;
        hold(10);
        checkOutput("postclr_count", 32'(count), 0);
        checkOutput("postclr_pulses", 32'(step_pulses), 0);

        // Illegal 00->11 jump sets sticky err.
        step_pulses = 0;
        applyStimulus(1'b1, 2'b11, 1'b0); hold(10);
        checkOutput("jump_err", 32'(err), 1);
        checkOutput("jump_count", 32'(count), 0);
        checkOutput("jump_pulses", 32'(step_pulses), 0);
        applyStimulus(1'b1, 2'b10, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b00, 1'b0); hold(10);
        checkOutput("sticky_err", 32'(err), 1);
        checkOutput("sticky_count", 32'(count), AFTER_JUMP);
        applyStimulus(1'b1, 2'b00, 1'b1); hold(1);
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkOutput("errclr_err", 32'(err), 0);
        checkOutput("errclr_count", 32'(count), 0);

        // Re-arm err, then reset in the middle of a debounce.
        applyStimulus(1'b1, 2'b11, 1'b0); hold(10);
        applyStimulus(1'b1, 2'b10, 1'b0); hold(10);
        checkOutput("rearm_err", 32'(err), 1);
        checkOutput("rearm_count", 32'(count), MID_COUNT);
        applyStimulus(1'b1, 2'b00, 1'b0); hold(3);
        applyStimulus(1'b0, 2'b00, 1'b0); hold(1);
        checkOutput("midrst_count", 32'(count), 0);
        checkOutput("midrst_dir", 32'(dir), 0);
        checkOutput("midrst_step", 32'(step), 0);
        checkOutput("midrst_err", 32'(err), 0);
        checkOutput("midrst_ready", 32'(ready), 0);
        applyStimulus(1'b1, 2'b00, 1'b0);
        hold(7);
        checkOutput("rerun_ready", 32'(ready), 1);
        checkOutput("rerun_count", 32'(count), 0);
        checkOutput("rerun_err", 32'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_gray_decoder.md
Name: quad_gray_decoder

Overview:
- Input-side counterpart to the seven-segment output path. Reads a 2-bit Gray-coded quadrature source (rotary encoder or two board switches) and turns it into a signed-direction position count.
- Covers the full input chain: 2-FF synchronisation, per-channel debounce, Gray-phase decode, wrap-around counter, and a sticky illegal-transition flag.
- `count` feeds the existing BCD/digit path for display.

Parameters:
- COUNT_W, 8, width of the position counter.
- DEB_CYC, 100000, cycles a synchronised input must differ from its filtered value before it is accepted (1 ms at 100 MHz); legal range ≥1.
- SETTLE_W, 20, width of the debounce and settle counters; must hold DEB_CYC+3.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  synchronous active-low reset.
- enc_a  input  1  asynchronous phase A, Gray bit 0.
- enc_b  input  1  asynchronous phase B, Gray bit 1.
- clr  input  1  synchronous clear of count and err; single-cycle or level.
- count  output  COUNT_W  position, unsigned, wraps.
- dir  output  1  direction of last accepted step; 1 = forward.
- step  output  1  one-cycle pulse per counted step.
- err  output  1  sticky illegal-transition flag.
- ready  output  1  high once the decoder is tracking.

Behaviour:
Reset and synchronisation
- Reset (rst_n=0 at a clk edge) values:
  - Outputs: count=0, dir=0, step=0, err=0, ready=0.
  - Internal: sync flops=0, filtered phase=00, debounce counters=0, FSM=INIT.
- Sync: s1<=pin, s2<=s1 for each channel.

Debounce (per channel)
- If s2==filt: cnt<=0.
- Else, if cnt==DEB_CYC-1: filt<=s2 and cnt<=0.
- Else: cnt++.
- Result: a raw change sampled into s1 at edge N appears in filt at edge N+DEB_CYC+1.
- Any bounce back to the filtered value restarts the count.

Phase
- ph={filt_b,filt_a}. Forward sequence is 00→01→11→10→00, i.e. A leads B.

FSM
- INIT:
  - Settle counter runs DEB_CYC+2 cycles.
  - Then prev<=ph, ready<=1, go to TRACK.
  - No step is generated, whatever ph is at that point.
- TRACK:
  - Each cycle prev<=ph.
  - If ph==prev: nothing.
  - If ph is the forward Gray successor of prev: forward event.
  - If ph is the predecessor: backward event.
  - If ph differs from prev in both bits (00↔11, 01↔10): err<=1, no count change, dir unchanged.
- Counted event: count±1 modulo 2^COUNT_W, dir<=event direction, step=1 for exactly one cycle.
- Latency: a counted event registers count/step/dir at edge N+DEB_CYC+2.

Counter rules
- Wrap: all-ones+1→0; 0−1→all-ones.

Clear
- clr=1 in TRACK: count<=0 and err<=0 that cycle.
- clr takes priority over a simultaneous step: count=0, step still pulses, dir still updates.
- prev tracking continues, so no false event after clr.
- clr in INIT: no effect beyond holding count/err at 0.

Reset mid-operation
- All state returns to reset values on the next edge; INIT re-runs.
- A partially debounced input is discarded.

Optional Feature:
- Macro: QUAD_X4_EN.
- Defined (x4 mode): every legal phase transition is a counted event, giving 4 counts per detent cycle.
- Undefined (x1 mode):
  - Only 10→00 (forward) and 00→10 (backward) are counted events.
  - Other legal transitions update prev and dir only, with no step and no count change.
  - Illegal-jump detection is identical in both modes.

Test Plan:
1. Reset, DEB_CYC=4, COUNT_W=8, inputs 00; release rst_n → ready rises on the 7th edge after release; count=0, err=0, no step pulses.
2. Inputs 11 held through reset release → ready rises, err=0, count=0 (INIT absorbs initial phase).
3. Forward cycle {b,a} 00→01→11→10→00, each held 10 cycles:
   - x1 mode: count=1, one step pulse, dir=1.
   - QUAD_X4_EN mode: count=4, four step pulses each 1 cycle wide.
4. Glitch: enc_a high for 3 cycles then low (DEB_CYC=4) → no filt change, count unchanged, no step.
5. From count 0, backward cycle 00→10→11→01→00:
   - x1 mode: count=255, dir=0.
   - x4 mode: count=252.
   - Then assert clr 1 cycle coincident with a forward step → count=0, step pulses, dir=1.
6. Jump 00→11 (both pins together, held 10 cycles) → err=1, count unchanged; err stays 1 after further legal steps until clr. Then assert rst_n=0 mid-debounce → all outputs at reset values on the next edge.
